// File: rtl/load_store_unit_if.sv
// Bus bundle between the execute stage, the load/store unit and dmem.
// The slave modport is the unit's view; the master modport drives requests and models dmem.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_we;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
               mem_addr, mem_wdata, mem_wmask, mem_we
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               mem_addr, mem_wdata, mem_wmask, mem_we
    );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: validates each request, drives dmem lanes and returns
// a registered, sign/zero-extended response with backpressure.
module load_store_unit #(
    parameter int MEM_SIZE = 1024
) (
    input  logic               clk,
    input  logic               rst,
    load_store_unit_if.slave   bus
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    localparam logic [31:0] MEM_SIZE_W = 32'(MEM_SIZE);

    logic [1:0]  state_q, state_d;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [1:0]  off_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic [3:0]  wmask_q;
    logic [31:0] resp_rdata_q;
    logic        resp_err_q;

    logic        accept;
    logic        req_bad;
    logic [31:0] lane_wdata;
    logic [3:0]  lane_wmask;
    logic [31:0] load_shifted;
    logic [31:0] load_result;

    assign accept = bus.req_valid && (state_q == ST_IDLE);

    // Request checks: illegal funct3, misalignment, or word index past the end of dmem.
    always_comb begin
        logic bad_f3;
        logic misaligned;
        logic out_of_range;
        bad_f3       = (bus.req_funct3 == 3'b011) || (bus.req_funct3[2:1] == 2'b11) ||
                       (bus.req_we && bus.req_funct3[2]);
        misaligned   = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                       ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
        out_of_range = ({2'b00, bus.req_addr[31:2]} >= MEM_SIZE_W);
        req_bad      = bad_f3 || misaligned || out_of_range;
    end

    always_comb begin
        lane_wdata = bus.req_wdata;
        lane_wmask = 4'b1111;
        case (bus.req_funct3[1:0])
            2'b00: begin
                lane_wdata = {4{bus.req_wdata[7:0]}};
                lane_wmask = 4'b0001 << bus.req_addr[1:0];
            end
            2'b01: begin
                lane_wdata = {2{bus.req_wdata[15:0]}};
                lane_wmask = 4'b0011 << bus.req_addr[1:0];
            end
            default: begin
                lane_wdata = bus.req_wdata;
                lane_wmask = 4'b1111;
            end
        endcase
        if (!bus.req_we) begin
            lane_wmask = 4'b0000;
        end
    end

    // Accepted loads are aligned, so shifting by the byte offset puts the field at bit 0.
    always_comb begin
        load_shifted = bus.mem_rdata >> {off_q, 3'b000};
        case (funct3_q)
            3'b000:  load_result = {{24{load_shifted[7]}}, load_shifted[7:0]};
            3'b100:  load_result = {24'd0, load_shifted[7:0]};
            3'b001:  load_result = {{16{load_shifted[15]}}, load_shifted[15:0]};
            3'b101:  load_result = {16'd0, load_shifted[15:0]};
            default: load_result = load_shifted;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (accept) state_d = req_bad ? ST_RESP : ST_ACCESS;
            ST_ACCESS: state_d = we_q ? ST_RESP : ST_WAIT;
            ST_WAIT:   state_d = ST_RESP;
            ST_RESP:   if (bus.resp_ready) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            we_q         <= 1'b0;
            funct3_q     <= 3'b000;
            off_q        <= 2'b00;
            mem_addr_q   <= 32'd0;
            mem_wdata_q  <= 32'd0;
            wmask_q      <= 4'b0000;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                we_q         <= bus.req_we;
                funct3_q     <= bus.req_funct3;
                off_q        <= bus.req_addr[1:0];
                mem_addr_q   <= {2'b00, bus.req_addr[31:2]};
                mem_wdata_q  <= lane_wdata;
                wmask_q      <= lane_wmask;
                resp_rdata_q <= 32'd0;
                resp_err_q   <= req_bad;
            end
            if (state_q == ST_WAIT) begin
                resp_rdata_q <= load_result;
            end
        end
    end

    assign bus.req_ready  = (state_q == ST_IDLE);
    assign bus.resp_valid = (state_q == ST_RESP);
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.mem_wmask  = (state_q == ST_ACCESS) ? wmask_q : 4'b0000;
    // rst gates the write combinationally so a store caught by reset never lands.
    assign bus.mem_we     = (state_q == ST_ACCESS) && we_q && !rst;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural dmem (registered read,
// byte-masked write) behind the memory side of the bus.
module tb_load_store_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   we_cnt = 0;

    load_store_unit_if bus ();

    load_store_unit #(.MEM_SIZE(1024)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:1023];
    logic [31:0] mem_rdata_q = 32'd0;
    assign bus.mem_rdata = mem_rdata_q;

    always @(posedge clk) begin
        if (bus.mem_addr < 32'd1024) begin
            mem_rdata_q <= mem[bus.mem_addr[9:0]];
            if (bus.mem_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (bus.mem_wmask[b]) mem[bus.mem_addr[9:0]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
                end
            end
        end
        if (bus.mem_we) we_cnt <= we_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, output logic [31:0] rd, output logic err,
                          output int lat, output logic [3:0] amask, output logic [31:0] aaddr,
                          output logic [31:0] awd, output logic awe);
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        bus.req_valid  = 1'b1;
        for (int i = 0; i < 20 && !bus.req_ready; i++) begin
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        amask = bus.mem_wmask;
        aaddr = bus.mem_addr;
        awd   = bus.mem_wdata;
        awe   = bus.mem_we;
        lat   = 1;
        while (!bus.resp_valid && lat < 12) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rd  = bus.resp_rdata;
        err = bus.resp_err;
        $display("req we=%0d f3=%03b addr=%h wdata=%h -> rdata=%h err=%0d lat=%0d",
                 we, f3, addr, wd, rd, err, lat);
    endtask

    task automatic consume();
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] rd, aaddr, awd, held;
        logic        err, awe;
        logic [3:0]  amask;
        int          lat, we_before;

        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'd0;
        bus.req_wdata  = 32'd0;
        bus.resp_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("reset req_ready",  32'(bus.req_ready), 32'd1);
        check("reset resp_valid", 32'(bus.resp_valid), 32'd0);
        check("reset resp_rdata", bus.resp_rdata, 32'd0);
        check("reset mem_wmask",  32'(bus.mem_wmask), 32'd0);
        check("reset mem_addr",   bus.mem_addr, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // SW then LW at 0x10
        do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd, err, lat, amask, aaddr, awd, awe);
        check("sw mask", 32'(amask), 32'hF);
        check("sw addr", aaddr, 32'd4);
        check("sw wdata", awd, 32'hDEADBEEF);
        check("sw we", 32'(awe), 32'd1);
        check("sw lat", 32'(lat), 32'd2);
        check("sw rdata", rd, 32'd0);
        consume();
        do_req(1'b0, 3'b010, 32'h10, 32'd0, rd, err, lat, amask, aaddr, awd, awe);
        check("lw addr", aaddr, 32'd4);
        check("lw rdata", rd, 32'hDEADBEEF);
        check("lw err", 32'(err), 32'd0);
        check("lw lat", 32'(lat), 32'd3);
        consume();
        do_req(1'b0, 3'b000, 32'h10, 32'd0, rd, err, lat, amask, aaddr, awd, awe);
        check("lb0 rdata", rd, 32'hFFFFFFEF);
        consume();
        do_req(1'b0, 3'b101, 32'h12, 32'd0, rd, err, lat, amask, aaddr, awd, awe);
        check("lhu2 rdata", rd, 32'h0000DEAD);
        consume();

        // SB at 0x13 and byte loads
        do_req(1'b1, 3'b000, 32'h13, 32'h000000A5, rd, err, lat, amask, aaddr, awd, awe);
        check("sb mask", 32'(amask), 32'h8);
        check("sb wdata", awd, 32'hA5A5A5A5);
        consume();
        do_req(1'b0, 3'b000, 32'h13, 32'd0, rd, err, lat, amask, aaddr, awd, awe);
        check("lb rdata", rd, 32'hFFFFFFA5);
        consume();
        do_req(1'b0, 3'b100, 32'h13, 32'd0, rd, err, lat, amask, aaddr, awd, awe);
        check("lbu rdata", rd, 32'h000000A5);
        consume();
        do_req(1'b0, 3'b010, 32'h10, 32'd0, rd, err, lat, amask, aaddr, awd, awe);
        check("lw after sb", rd, 32'hA5ADBEEF);
        consume();

        // SH at 0x22 and halfword loads
        do_req(1'b1, 3'b001, 32'h22, 32'h00008001, rd, err, lat, amask, aaddr, awd, awe);
        check("sh mask", 32'(amask), 32'hC);
        check("sh wdata", awd, 32'h80018001);
        check("sh addr", aaddr, 32'd8);
        consume();
        do_req(1'b0, 3'b001, 32'h22, 32'd0, rd, err, lat, amask, aaddr, awd, awe);
        check("lh rdata", rd, 32'hFFFF8001);
        consume();
        do_req(1'b0, 3'b101, 32'h22, 32'd0, rd, err, lat, amask, aaddr, awd, awe);
        check("lhu rdata", rd, 32'h00008001);
        consume();

        // Bad requests: misaligned, illegal funct3, out of range, store with unsigned funct3
        we_before = we_cnt;
        do_req(1'b0, 3'b010, 32'h12, 32'd0, rd, err, lat, amask, aaddr, awd, awe);
        check("lw mis err", 32'(err), 32'd1);
        check("lw mis rdata", rd, 32'd0);
        check("lw mis lat", 32'(lat), 32'd1);
        consume();
        do_req(1'b0, 3'b001, 32'h01, 32'd0, rd, err, lat, amask, aaddr, awd, awe);
        check("lh mis err", 32'(err), 32'd1);
        check("lh mis lat", 32'(lat), 32'd1);
        consume();
        do_req(1'b0, 3'b011, 32'h00, 32'd0, rd, err, lat, amask, aaddr, awd, awe);
        check("f3 011 err", 32'(err), 32'd1);
        check("f3 011 rdata", rd, 32'd0);
        consume();
        do_req(1'b1, 3'b000, 32'h1000, 32'h11, rd, err, lat, amask, aaddr, awd, awe);
        check("sb range err", 32'(err), 32'd1);
        check("sb range lat", 32'(lat), 32'd1);
        check("sb range mask", 32'(amask), 32'd0);
        consume();
        do_req(1'b1, 3'b100, 32'h10, 32'h11, rd, err, lat, amask, aaddr, awd, awe);
        check("sbu err", 32'(err), 32'd1);
        consume();
        do_req(1'b0, 3'b010, 32'h0FFC, 32'd0, rd, err, lat, amask, aaddr, awd, awe);
        check("lw last word err", 32'(err), 32'd0);
        consume();
        check("err no writes", 32'(we_cnt - we_before), 32'd0);
        do_req(1'b0, 3'b010, 32'h10, 32'd0, rd, err, lat, amask, aaddr, awd, awe);
        check("lw after errs", rd, 32'hA5ADBEEF);
        consume();

        // Backpressure on an LW response
        do_req(1'b0, 3'b010, 32'h10, 32'd0, rd, err, lat, amask, aaddr, awd, awe);
        held = rd;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp resp_valid", 32'(bus.resp_valid), 32'd1);
            check("bp rdata", bus.resp_rdata, 32'hA5ADBEEF);
            check("bp req_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.req_valid = 1'b0;
        check("bp held", held, 32'hA5ADBEEF);
        consume();
        check("bp release resp_valid", 32'(bus.resp_valid), 32'd0);
        check("bp release req_ready", 32'(bus.req_ready), 32'd1);

        // Reset during the ACCESS cycle of a store
        do_req(1'b1, 3'b010, 32'h40, 32'h12345678, rd, err, lat, amask, aaddr, awd, awe);
        consume();
        we_before = we_cnt;
        bus.req_we     = 1'b1;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h40;
        bus.req_wdata  = 32'hCAFEF00D;
        bus.req_valid  = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        check("rst acc we before", 32'(bus.mem_we), 32'd1);
        rst = 1'b1;
        #1;
        check("rst acc we gated", 32'(bus.mem_we), 32'd0);
        @(posedge clk);
        #1;
        check("rst req_ready",  32'(bus.req_ready), 32'd1);
        check("rst resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst resp_err",   32'(bus.resp_err), 32'd0);
        check("rst resp_rdata", bus.resp_rdata, 32'd0);
        check("rst mem_addr",   bus.mem_addr, 32'd0);
        check("rst mem_wdata",  bus.mem_wdata, 32'd0);
        check("rst mem_wmask",  32'(bus.mem_wmask), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("rst no resp", 32'(bus.resp_valid), 32'd0);
        end
        check("rst no write", 32'(we_cnt - we_before), 32'd0);
        do_req(1'b0, 3'b010, 32'h40, 32'd0, rd, err, lat, amask, aaddr, awd, awe);
        check("lw old value", rd, 32'h12345678);
        consume();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
